alu_sequencer: RTL and testbench
================================

Name: alu_sequencer

Overview:
- Multi-cycle control unit for the 8-bit accumulator datapath. It fetches 12-bit instructions over a req/ack instruction-memory port, decodes them, and reads or writes an 8-entry register file.
- It drives the ALU opcode and operands, then captures the ALU result into the accumulator and the status flags into a flag register.
- Sits between instruction memory, register file and ALU at the processor top level.

Parameters:
- PC_W, 8, program counter / instruction address width
- RESET_PC, 8'h00, PC value loaded on reset and on start

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  asynchronous, active-high reset
- start  in  1  one-cycle pulse; leaves IDLE and begins execution at RESET_PC
- imem_req  out  1  fetch request, held until acknowledged
- imem_addr  out  PC_W  fetch address (= pc)
- imem_ack  in  1  fetch acknowledge; imem_data valid in the same cycle
- imem_data  in  12  instruction word
- rf_addr  out  3  register-file index (= ir[2:0])
- rf_rdata  in  8  register-file read data, combinational from rf_addr
- rf_we  out  1  register-file write enable, one cycle
- rf_wdata  out  8  register-file write data (= acc)
- alu_instr_code  out  4  ALU opcode (= ir[7:4])
- alu_acc  out  8  ALU accumulator operand (= acc)
- alu_reg  out  8  ALU register operand (= rf_rdata)
- alu_result  in  8  ALU result
- alu_flag_z, alu_flag_cy, alu_flag_p, alu_flag_s  in  1 each  ALU flags
- acc  out  8  accumulator register
- flags  out  5  {s,p,ov,cy,z} flag register
- pc  out  PC_W  program counter
- busy  out  1  high in every state except IDLE and HALT
- halted  out  1  high in HALT

Behaviour:
- Reset (asynchronous, immediate):
  - state=IDLE, pc=RESET_PC, acc=0, flags=0, ir=0.
  - imem_req=0, rf_we=0, busy=0, halted=0.
  - Reset asserted mid-fetch drops imem_req in the same cycle with no clock edge needed.
- Instruction word:
  - ir[11:8] class; ir[7:4] ALU code; ir[2:0] register index; ir[7:0] imm8/target.
  - Classes: 0 ALU, 1 LDA, 2 STA, 3 LDI, 4 JMP, 5 JZ, 6 JC, 7 HALT, 8-15 NOP.
- IDLE: start=1 -> pc=RESET_PC, FETCH. start in any other state is ignored.
- FETCH:
  - imem_req=1, imem_addr=pc.
  - On a cycle with imem_ack=1: ir<=imem_data, pc<=pc+1 (wraps 0xFF->0x00), -> DECODE.
  - imem_ack while imem_req=0 is ignored.
- DECODE: rf_addr valid (one cycle for register read settle) -> EXECUTE.
- EXECUTE (single cycle), then -> FETCH unless stated:
  - ALU: acc<=alu_result; z,p,s<=ALU flags; cy<=alu_flag_cy only when ALU code = `ADD`, else cy unchanged; ov unchanged.
  - LDA: acc<=rf_rdata; z<=(rf_rdata==0); other flags unchanged.
  - STA: rf_we=1 for this cycle, rf_wdata=acc, rf_addr=ir[2:0].
  - LDI: acc<=ir[7:0]; z<=(imm==0).
  - JMP: pc<=ir[7:0].
  - JZ: pc<=ir[7:0] if flags.z=1, else pc unchanged.
  - JC: pc<=ir[7:0] if flags.cy=1, else pc unchanged.
  - HALT: -> HALT.
  - NOP: no state change other than the transition to FETCH.
- HALT: halted=1, busy=0, all outputs frozen. Exit only by rst.
- Timing: 3 cycles plus fetch wait per instruction. With imem_ack tied high, one instruction completes every 3 cycles.
- ov: flags[2] is reserved and held 0; the ALU does not drive it.
- Output timing: alu_instr_code/alu_acc/alu_reg are driven continuously from ir/acc/rf_rdata. Only EXECUTE captures alu_result.
- Flag update timing: all flag updates take effect at the EXECUTE clock edge. A JZ/JC immediately following an ALU op sees the updated flags.

Test Plan:
- Reset/start: assert rst mid-FETCH -> imem_req=0 immediately, pc=0, acc=0. start pulse -> imem_req=1, imem_addr=0 next cycle.
- LDI 0x3C, STA r2, LDI 0x05, ADD r2 with ack tied high -> rf write r2=0x3C; acc=0x41, z=0, cy=0, p=1, s=0; pc=4 after 12 cycles.
- LDI 0xFF, STA r1, LDI 0x01, ADD r1, JC 0x20 -> acc=0x00, z=1, cy=1, next imem_addr=0x20.
- Fetch wait: hold imem_ack low 5 cycles -> imem_req stays 1, imem_addr stable, pc unchanged. Ack -> DECODE next cycle.
- PC wrap: JMP 0xFF, then NOP at 0xFF -> next fetch address 0x00.
- HALT at address 3 -> halted=1, busy=0, imem_req=0. start pulses ignored; rst returns to IDLE.

Source files
------------

// File: rtl/alu_sequencer_if.sv
// Sequencer-side bundle: instruction fetch port, register-file port and ALU operand/result port.
interface alu_sequencer_if #(
    parameter int PC_W = 8
);
    logic            imem_req;
    logic [PC_W-1:0] imem_addr;
    logic            imem_ack;
    logic [11:0]     imem_data;
    logic [2:0]      rf_addr;
    logic [7:0]      rf_rdata;
    logic            rf_we;
    logic [7:0]      rf_wdata;
    logic [3:0]      alu_instr_code;
    logic [7:0]      alu_acc;
    logic [7:0]      alu_reg;
    logic [7:0]      alu_result;
    logic            alu_flag_z;
    logic            alu_flag_cy;
    logic            alu_flag_p;
    logic            alu_flag_s;

    modport master (
        output imem_req, imem_addr, input imem_ack, imem_data,
        output rf_addr, input rf_rdata, output rf_we, rf_wdata,
        output alu_instr_code, alu_acc, alu_reg,
        input  alu_result, alu_flag_z, alu_flag_cy, alu_flag_p, alu_flag_s
    );

    modport slave (
        input  imem_req, imem_addr, output imem_ack, imem_data,
        input  rf_addr, output rf_rdata, input rf_we, rf_wdata,
        input  alu_instr_code, alu_acc, alu_reg,
        output alu_result, alu_flag_z, alu_flag_cy, alu_flag_p, alu_flag_s
    );
endinterface

// File: rtl/alu_sequencer.sv
// Multi-cycle control unit for the 8-bit accumulator datapath:
// FETCH -> DECODE -> EXECUTE per instruction, with a sticky HALT left only through rst.
module alu_sequencer #(
    parameter int              PC_W     = 8,
    parameter logic [PC_W-1:0] RESET_PC = '0
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    alu_sequencer_if.master bus,
    output logic [7:0]      acc,
    output logic [4:0]      flags,
    output logic [PC_W-1:0] pc,
    output logic            busy,
    output logic            halted
);
    typedef enum logic [2:0] {S_IDLE, S_FETCH, S_DECODE, S_EXEC, S_HALT} state_t;

    localparam logic [3:0] C_ALU  = 4'd0;
    localparam logic [3:0] C_LDA  = 4'd1;
    localparam logic [3:0] C_STA  = 4'd2;
    localparam logic [3:0] C_LDI  = 4'd3;
    localparam logic [3:0] C_JMP  = 4'd4;
    localparam logic [3:0] C_JZ   = 4'd5;
    localparam logic [3:0] C_JC   = 4'd6;
    localparam logic [3:0] C_HALT = 4'd7;
    localparam logic [3:0] ALU_ADD = 4'd0;

    // flags bit positions: {s,p,ov,cy,z}; ov is never written and stays 0
    localparam int F_Z = 0, F_CY = 1, F_P = 3, F_S = 4;

    state_t     state, state_nx;
    logic [11:0] ir;
    logic [3:0]  cls;
    logic [PC_W-1:0] target;

    assign cls    = ir[11:8];
    assign target = PC_W'(ir[7:0]);

    assign bus.imem_addr      = pc;
    assign bus.rf_addr        = ir[2:0];
    assign bus.rf_wdata       = acc;
    assign bus.alu_instr_code = ir[7:4];
    assign bus.alu_acc        = acc;
    assign bus.alu_reg        = bus.rf_rdata;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= S_IDLE;
        else     state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            S_IDLE:   if (start) state_nx = S_FETCH;
            S_FETCH:  if (bus.imem_ack) state_nx = S_DECODE;
            S_DECODE: state_nx = S_EXEC;
            S_EXEC:   state_nx = (cls == C_HALT) ? S_HALT : S_FETCH;
            S_HALT:   state_nx = S_HALT;
            default:  state_nx = S_IDLE;
        endcase
    end

    // Outputs decode straight from state so reset removes imem_req without a clock edge
    always_comb begin
        bus.imem_req = (state == S_FETCH);
        bus.rf_we    = (state == S_EXEC) && (cls == C_STA);
        busy         = (state == S_FETCH) || (state == S_DECODE) || (state == S_EXEC);
        halted       = (state == S_HALT);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc    <= RESET_PC;
            ir    <= '0;
            acc   <= '0;
            flags <= '0;
        end else begin
            case (state)
                S_IDLE: if (start) pc <= RESET_PC;
                S_FETCH: if (bus.imem_ack) begin
                    ir <= bus.imem_data;
                    pc <= pc + PC_W'(1);
                end
                S_EXEC: begin
                    case (cls)
                        C_ALU: begin
                            acc        <= bus.alu_result;
                            flags[F_Z] <= bus.alu_flag_z;
                            flags[F_P] <= bus.alu_flag_p;
                            flags[F_S] <= bus.alu_flag_s;
                            if (ir[7:4] == ALU_ADD) flags[F_CY] <= bus.alu_flag_cy;
                        end
                        C_LDA: begin
                            acc        <= bus.rf_rdata;
                            flags[F_Z] <= (bus.rf_rdata == 8'h00);
                        end
                        C_LDI: begin
                            acc        <= ir[7:0];
                            flags[F_Z] <= (ir[7:0] == 8'h00);
                        end
                        C_JMP: pc <= target;
                        C_JZ:  if (flags[F_Z])  pc <= target;
                        C_JC:  if (flags[F_CY]) pc <= target;
                        default: ;
                    endcase
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_alu_sequencer.sv
// Directed bench: bench-side imem/RF/ALU, an instruction-level model checked at every fetch, and literal checkpoints.
module tb_alu_sequencer;
    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic       ack_en;
    logic [7:0] acc;
    logic [4:0] flags;
    logic [7:0] pc;
    logic       busy, halted;

    int checks = 0;
    int failures = 0;

    alu_sequencer_if #(.PC_W(8)) bus ();

    alu_sequencer #(.PC_W(8), .RESET_PC(8'h00)) dut (
        .clk(clk), .rst(rst), .start(start), .bus(bus),
        .acc(acc), .flags(flags), .pc(pc), .busy(busy), .halted(halted)
    );

    always #5 clk = ~clk;

    logic [11:0] imem [0:255];
    logic [7:0]  rf [0:7] = '{default: 8'h00};

    // Bench ALU: code 0 = ADD (carry out), 1 = AND, others XOR; carry only meaningful for ADD
    function automatic logic [8:0] alu_f(input logic [3:0] c, input logic [7:0] a, input logic [7:0] b);
        case (c)
            4'd0:    return {1'b0, a} + {1'b0, b};
            4'd1:    return {1'b0, a & b};
            default: return {1'b0, a ^ b};
        endcase
    endfunction

    logic [8:0] alu_o;
    assign alu_o           = alu_f(bus.alu_instr_code, bus.alu_acc, bus.alu_reg);
    assign bus.alu_result  = alu_o[7:0];
    assign bus.alu_flag_cy = alu_o[8];
    assign bus.alu_flag_z  = (alu_o[7:0] == 8'h00);
    assign bus.alu_flag_p  = ~^alu_o[7:0];
    assign bus.alu_flag_s  = alu_o[7];
    assign bus.imem_ack    = ack_en;
    assign bus.imem_data   = imem[bus.imem_addr];
    assign bus.rf_rdata    = rf[bus.rf_addr];

    always @(posedge clk) if (bus.rf_we) rf[bus.rf_addr] <= bus.rf_wdata;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Instruction-level model: architectural state advanced one whole instruction per fetch handshake
    logic [7:0] m_pc, m_acc;
    logic       m_z, m_cy, m_p, m_s, m_run, m_halted;
    logic [2:0] m_sta_idx;
    logic [7:0] m_rf [0:7] = '{default: 8'h00};
    logic [11:0] ins;
    logic [8:0]  r;

    always @(negedge clk) begin
        if (rst) begin
            m_pc = 8'h00; m_acc = 8'h00; m_run = 1'b0; m_halted = 1'b0;
            {m_z, m_cy, m_p, m_s} = 4'b0;
        end else if (start && !m_run) begin
            m_run = 1'b1;
            m_pc  = 8'h00;
        end else if (bus.imem_req && bus.imem_ack) begin
            chk("fetch_addr", bus.imem_addr, m_pc);
            chk("fetch_acc", acc, m_acc);
            chk("fetch_flags", flags, {m_s, m_p, 1'b0, m_cy, m_z});
            ins  = bus.imem_data;
            m_pc = m_pc + 8'd1;
            case (ins[11:8])
                4'd0: begin
                    r = alu_f(ins[7:4], m_acc, m_rf[ins[2:0]]);
                    m_acc = r[7:0];
                    m_z = (r[7:0] == 0); m_p = ~^r[7:0]; m_s = r[7];
                    if (ins[7:4] == 4'd0) m_cy = r[8];
                end
                4'd1: begin m_acc = m_rf[ins[2:0]]; m_z = (m_acc == 0); end
                4'd2: begin m_rf[ins[2:0]] = m_acc; m_sta_idx = ins[2:0]; end
                4'd3: begin m_acc = ins[7:0]; m_z = (m_acc == 0); end
                4'd4: m_pc = ins[7:0];
                4'd5: if (m_z)  m_pc = ins[7:0];
                4'd6: if (m_cy) m_pc = ins[7:0];
                4'd7: m_halted = 1'b1;
                default: ;
            endcase
        end
        if (!rst && bus.rf_we) begin
            chk("rf_we_addr", bus.rf_addr, m_sta_idx);
            chk("rf_we_data", bus.rf_wdata, m_acc);
        end
    end

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic fill(input logic [11:0] v);
        for (int i = 0; i < 256; i++) imem[i] = v;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        step(1);
        start = 1'b0;
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; ack_en = 1'b0;
        fill(12'h700);
        imem[0] = 12'h377;
        step(1);
        chk("rst_req", bus.imem_req, 1'b0);
        chk("rst_busy", busy, 1'b0);
        chk("rst_halted", halted, 1'b0);
        chk("rst_pc", pc, 8'h00);
        chk("rst_acc", acc, 8'h00);
        chk("rst_flags", flags, 5'h00);
        chk("rst_we", bus.rf_we, 1'b0);
        rst = 1'b0;
        step(1);

        // Fetch wait: request held, address and pc stable while ack is low
        pulse_start();
        chk("start_req", bus.imem_req, 1'b1);
        chk("start_addr", bus.imem_addr, 8'h00);
        for (int i = 0; i < 5; i++) begin
            step(1);
            chk("wait_req", bus.imem_req, 1'b1);
            chk("wait_addr", bus.imem_addr, 8'h00);
            chk("wait_pc", pc, 8'h00);
        end
        ack_en = 1'b1;
        step(1);
        ack_en = 1'b0;
        chk("ack_pc", pc, 8'h01);
        chk("decode_req", bus.imem_req, 1'b0);
        chk("decode_busy", busy, 1'b1);
        step(2);
        chk("ldi77_acc", acc, 8'h77);
        chk("refetch_req", bus.imem_req, 1'b1);
        // Asynchronous reset in the middle of a fetch wait
        #2 rst = 1'b1;
        #1;
        chk("async_req", bus.imem_req, 1'b0);
        chk("async_pc", pc, 8'h00);
        chk("async_acc", acc, 8'h00);
        chk("async_busy", busy, 1'b0);
        step(1);
        rst = 1'b0;

        // Arithmetic / carry / jump / wrap program, ack tied high
        fill(12'h700);
        imem[0] = 12'h33C; imem[1] = 12'h202; imem[2] = 12'h305; imem[3] = 12'h002;
        imem[4] = 12'h3FF; imem[5] = 12'h201; imem[6] = 12'h301; imem[7] = 12'h001;
        imem[8] = 12'h620;
        imem[8'h20] = 12'h012; imem[8'h21] = 12'h102; imem[8'h22] = 12'h540;
        imem[8'h23] = 12'h4FF; imem[8'hFF] = 12'h800;
        ack_en = 1'b1;
        pulse_start();
        step(12);
        chk("add_pc", pc, 8'h04);
        chk("add_acc", acc, 8'h41);
        chk("add_flags", flags, 5'h08);
        chk("sta_r2", rf[2], 8'h3C);
        step(15);
        chk("carry_acc", acc, 8'h00);
        chk("carry_flags", flags, 5'h0B);
        chk("jc_addr", bus.imem_addr, 8'h20);
        chk("jc_req", bus.imem_req, 1'b1);
        step(15);
        chk("wrap_addr", bus.imem_addr, 8'h00);
        chk("wrap_pc", pc, 8'h00);
        chk("wrap_acc", acc, 8'h3C);
        chk("wrap_flags", flags, 5'h0A);
        rst = 1'b1;
        step(1);
        rst = 1'b0;

        // HALT at address 3, reached through a taken JZ
        fill(12'h700);
        imem[0] = 12'h300; imem[1] = 12'h503; imem[2] = 12'h3AA; imem[3] = 12'h700;
        pulse_start();
        step(12);
        chk("halt_halted", halted, 1'b1);
        chk("halt_busy", busy, 1'b0);
        chk("halt_req", bus.imem_req, 1'b0);
        chk("halt_acc", acc, 8'h00);
        chk("halt_pc", pc, 8'h04);
        pulse_start();
        step(3);
        chk("halt_start_ign", halted, 1'b1);
        chk("halt_pc_frozen", pc, 8'h04);
        chk("halt_req_frozen", bus.imem_req, 1'b0);
        rst = 1'b1;
        #1;
        chk("halt_rst_halted", halted, 1'b0);
        chk("halt_rst_busy", busy, 1'b0);
        step(1);
        rst = 1'b0;
        step(1);
        for (int i = 0; i < 8; i++) chk("rf_final", rf[i], m_rf[i]);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
